button_conditioner: RTL and testbench

Input-side counterpart to the stopwatch display path. It takes the raw board controls (btnS, btnR, sel, adj) and turns them into clean signals on the clk domain:
- one-cycle press events for the two buttons
- a latched pause level
- debounced sel/adj levels

The stopwatch counter and FSM consume these outputs instead of the raw pins.

---
 rtl/button_conditioner.sv | 123 ++++++++++++
 tb/tb_button_conditioner.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Raw board controls -> synchronized, debounced levels plus one-cycle press events.
// Define LONG_PRESS_EN to add long_pulse, a "clear and run" event on a long btnS hold.
module button_conditioner_db #(
  parameter int DB_CYCLES = 1000000,
  parameter int CNT_W     = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db
);
  logic             s1, s2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      db  <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module button_conditioner #(
  parameter int DB_CYCLES   = 1000000,
  parameter int CNT_W       = 20,
  parameter int LONG_CYCLES = 100000000,
  parameter int LONG_W      = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic btnS,
  input  logic btnR,
  input  logic sel,
  input  logic adj,
  output logic pause_pulse,
  output logic rst_pulse,
  output logic paused,
  output logic sel_db,
  output logic adj_db
`ifdef LONG_PRESS_EN
  ,
  output logic long_pulse
`endif
);
  localparam int NUM_CH = 4;

  logic [NUM_CH-1:0] raw, db;
  logic              dbs_q, dbr_q;
  logic              long_fire, long_clr;

  assign raw = {adj, sel, btnR, btnS};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    button_conditioner_db #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_ch (
      .clk(clk),
      .rst(rst),
      .raw(raw[i]),
      .db (db[i])
    );
  end

  assign sel_db = db[2];
  assign adj_db = db[3];

`ifdef LONG_PRESS_EN
  logic [LONG_W-1:0] lcnt;

  assign long_fire = db[0] && (lcnt == LONG_W'(LONG_CYCLES - 1));
  assign long_clr  = long_pulse;

  // Saturating hold counter: one event per hold, cleared on release.
  always_ff @(posedge clk) begin
    if (rst) begin
      lcnt       <= '0;
      long_pulse <= 1'b0;
    end else begin
      long_pulse <= long_fire;
      if (!db[0])
        lcnt <= '0;
      else if (lcnt != LONG_W'(LONG_CYCLES))
        lcnt <= lcnt + 1'b1;
    end
  end
`else
  logic [LONG_W-1:0] unused_long;
  assign unused_long = LONG_W'(LONG_CYCLES);
  assign long_fire   = 1'b0;
  assign long_clr    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      dbs_q       <= 1'b0;
      dbr_q       <= 1'b0;
      pause_pulse <= 1'b0;
      rst_pulse   <= 1'b0;
      paused      <= 1'b0;
    end else begin
      dbs_q       <= db[0];
      dbr_q       <= db[1];
      pause_pulse <= db[0] & ~dbs_q;
      rst_pulse   <= db[1] & ~dbr_q & ~long_fire;
      // Reset (or a long hold) wins over a coincident pause toggle.
      if (rst_pulse || long_clr)
        paused <= 1'b0;
      else if (pause_pulse)
        paused <= ~paused;
    end
  end
endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DB_CYCLES=4 (and LONG_CYCLES=8 when enabled).
module tb_button_conditioner;
  logic clk = 1'b0;
  logic rst, btnS, btnR, sel, adj;
  logic pause_pulse, rst_pulse, paused, sel_db, adj_db;
`ifdef LONG_PRESS_EN
  logic long_pulse;
  int   n_long;
`endif
  int errs = 0, n_chk = 0;
  int n_pp, n_rp;

  always #5 clk = ~clk;

  button_conditioner #(.DB_CYCLES(4), .CNT_W(3), .LONG_CYCLES(8), .LONG_W(4)) dut (
    .clk(clk), .rst(rst), .btnS(btnS), .btnR(btnR), .sel(sel), .adj(adj),
    .pause_pulse(pause_pulse), .rst_pulse(rst_pulse), .paused(paused),
    .sel_db(sel_db), .adj_db(adj_db)
`ifdef LONG_PRESS_EN
    , .long_pulse(long_pulse)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1 time unit later, tally pulses.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      n_pp += int'(pause_pulse);
      n_rp += int'(rst_pulse);
`ifdef LONG_PRESS_EN
      n_long += int'(long_pulse);
`endif
    end
  endtask

  task automatic clr_cnt();
    n_pp = 0;
    n_rp = 0;
`ifdef LONG_PRESS_EN
    n_long = 0;
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    clr_cnt();
  endtask

  // Clean press: high for hi steps, low for lo steps.
  task automatic press_s(input int hi, input int lo);
    btnS = 1'b1;
    step(hi);
    btnS = 1'b0;
    step(lo);
  endtask

  initial begin
    rst = 1'b0; btnS = 1'b0; btnR = 1'b0; sel = 1'b0; adj = 1'b0;
    clr_cnt();
    step(1);
    do_reset();
    chk("rst_pause_pulse", pause_pulse, 0);
    chk("rst_rst_pulse", rst_pulse, 0);
    chk("rst_paused", paused, 0);
    chk("rst_sel_db", sel_db, 0);
    chk("rst_adj_db", adj_db, 0);

    // 1: long clean hold, pulse after 7th edge, paused after 8th
    btnS = 1'b1;
    step(6);
    chk("t1_no_pulse_early", pause_pulse, 0);
    step(1);
    chk("t1_pulse", pause_pulse, 1);
    chk("t1_paused_before", paused, 0);
    step(1);
    chk("t1_pulse_one_cycle", pause_pulse, 0);
    chk("t1_paused", paused, 1);
    step(12);
    chk("t1_pulse_count", n_pp, 1);
    btnS = 1'b0;
    clr_cnt();
    step(12);
    chk("t1_release_no_pulse", n_pp, 0);
    chk("t1_paused_held", paused, 1);

    // 2: 3-cycle glitches stay below the debounce threshold
    clr_cnt();
    press_s(3, 5);
    press_s(3, 10);
    chk("t2_glitch_pulses", n_pp, 0);
    chk("t2_glitch_paused", paused, 1);

    // 3: two clean presses from paused=0
    do_reset();
    press_s(10, 10);
    chk("t3_paused_first", paused, 1);
    press_s(10, 10);
    chk("t3_paused_second", paused, 0);
    chk("t3_pulse_count", n_pp, 2);

    // rst_pulse alone clears paused
    press_s(10, 10);
    chk("t3b_paused_set", paused, 1);
    clr_cnt();
    btnR = 1'b1;
    step(7);
    chk("t3b_rst_pulse", rst_pulse, 1);
    step(1);
    chk("t3b_paused_cleared", paused, 0);
    btnR = 1'b0;
    step(10);
    chk("t3b_rst_count", n_rp, 1);

    // 4: simultaneous press, reset wins
    press_s(10, 10);
    chk("t4_paused_set", paused, 1);
    clr_cnt();
    btnS = 1'b1; btnR = 1'b1;
    step(7);
    chk("t4_pause_pulse", pause_pulse, 1);
    chk("t4_rst_pulse", rst_pulse, 1);
    step(1);
    chk("t4_paused", paused, 0);
    btnS = 1'b0; btnR = 1'b0;
    step(10);
    chk("t4_paused_after", paused, 0);
    chk("t4_pp_count", n_pp, 1);
    chk("t4_rp_count", n_rp, 1);

    // 5: reset mid-debounce discards the partial count
    clr_cnt();
    btnS = 1'b1;
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(2);
    btnS = 1'b0;
    step(10);
    chk("t5_no_pulse_after_rst", n_pp, 0);
    chk("t5_paused", paused, 0);
    btnS = 1'b1;
    step(6);
    chk("t5_no_pulse_5", pause_pulse, 0);
    step(1);
    chk("t5_pulse_after_rst", pause_pulse, 1);
    btnS = 1'b0;
    step(10);

    // adj / sel level latency, both directions
    adj = 1'b1;
    step(5);
    chk("t5_adj_early", adj_db, 0);
    step(1);
    chk("t5_adj_rise", adj_db, 1);
    sel = 1'b1;
    adj = 1'b0;
    step(5);
    chk("t5_sel_early", sel_db, 0);
    chk("t5_adj_hold", adj_db, 1);
    step(1);
    chk("t5_sel_rise", sel_db, 1);
    chk("t5_adj_fall", adj_db, 0);
    sel = 1'b0;
    step(3);
    sel = 1'b1;
    step(8);
    chk("t5_sel_glitch_low", sel_db, 1);

`ifdef LONG_PRESS_EN
    // 6: long press clears pause, no rst_pulse
    do_reset();
    press_s(10, 10);
    chk("t6_paused_set", paused, 1);
    clr_cnt();
    btnS = 1'b1;
    step(8);
    chk("t6_paused_toggled", paused, 0);
    step(5);
    chk("t6_long_early", long_pulse, 0);
    step(1);
    chk("t6_long_pulse", long_pulse, 1);
    step(1);
    chk("t6_long_one_cycle", long_pulse, 0);
    step(15);
    btnS = 1'b0;
    step(10);
    chk("t6_long_count", n_long, 1);
    chk("t6_pp_count", n_pp, 1);
    chk("t6_rp_count", n_rp, 0);
    chk("t6_paused_final", paused, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, n_chk);
    $finish;
  end
endmodule
